pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the P5 core. It generalises the fixed-width W-stage register.

---
 rtl/pipe_stage_reg.sv | 195 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised inter-stage pipeline register with valid/ready flow control.
//   Carries one PC field plus NFIELD payload fields of DATA_W bits each.
//   With SKID=1 the stage is a 2-entry buffer whose ready output is purely
//   registered. This breaks the combinational path from downstream ready to
//   upstream ready. With SKID=0 the stage is a single register whose ready
//   output is combinational.
//   Flush kills every held beat and inserts a bubble. A saturating counter
//   counts the cycles in which the output was not valid.
//
// Ports
//   pipe_stage_reg_clk_i    clock, rising edge
//   pipe_stage_reg_clrn_i   synchronous reset, active low
//   pipe_stage_reg_vld_i    upstream beat valid
//   pipe_stage_reg_rdy_o    stage can accept a beat
//   pipe_stage_reg_pc_i     upstream PC
//   pipe_stage_reg_dat_i    upstream payload (NFIELD*DATA_W, flattened)
//   pipe_stage_reg_flush_i  kill all held beats on this edge
//   pipe_stage_reg_vld_o    downstream beat valid
//   pipe_stage_reg_rdy_i    downstream accepts
//   pipe_stage_reg_pc_o     held PC
//   pipe_stage_reg_dat_o    held payload
//   pipe_stage_reg_bub_o    count of cycles with vld_o low since reset (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int              DATA_W = 32,
    parameter int              NFIELD = 4,
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] PC_RST = 'h3000,
    parameter int              SKID   = 1,
    parameter int              CNT_W  = 16
) (
    input  logic                     pipe_stage_reg_clk_i,
    input  logic                     pipe_stage_reg_clrn_i,
    input  logic                     pipe_stage_reg_vld_i,
    output logic                     pipe_stage_reg_rdy_o,
    input  logic [PC_W-1:0]          pipe_stage_reg_pc_i,
    input  logic [NFIELD*DATA_W-1:0] pipe_stage_reg_dat_i,
    input  logic                     pipe_stage_reg_flush_i,
    output logic                     pipe_stage_reg_vld_o,
    input  logic                     pipe_stage_reg_rdy_i,
    output logic [PC_W-1:0]          pipe_stage_reg_pc_o,
    output logic [NFIELD*DATA_W-1:0] pipe_stage_reg_dat_o,
    output logic [CNT_W-1:0]         pipe_stage_reg_bub_o
);

    localparam int PAY_W = NFIELD * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    logic              w_vld;
    logic              w_rdy;
    logic [PC_W-1:0]   w_pc;
    logic [PAY_W-1:0]  w_dat;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = pipe_stage_reg_vld_i & w_rdy;
    assign w_drain  = w_vld & pipe_stage_reg_rdy_i;

    generate
        if (SKID != 0) begin : g_skid
            state_t           r_state;
            state_t           w_state_next;
            logic             w_load_main;
            logic             w_main_from_skid;
            logic             w_load_skid;
            logic [PC_W-1:0]  r_main_pc;
            logic [PAY_W-1:0] r_main_dat;
            logic [PC_W-1:0]  r_skid_pc;
            logic [PAY_W-1:0] r_skid_dat;

            // The main register always holds the oldest beat. The skid register
            // only catches the beat that arrives while the output is stalled.
            always_comb begin
                w_state_next     = r_state;
                w_load_main      = 1'b0;
                w_main_from_skid = 1'b0;
                w_load_skid      = 1'b0;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            w_state_next = ST_FULL;
                            w_load_main  = 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (w_accept && w_drain) begin
                            w_load_main = 1'b1;
                        end else if (w_accept) begin
                            w_state_next = ST_SKID;
                            w_load_skid  = 1'b1;
                        end else if (w_drain) begin
                            w_state_next = ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (w_drain) begin
                            w_state_next     = ST_FULL;
                            w_main_from_skid = 1'b1;
                        end
                    end
                    default: w_state_next = ST_EMPTY;
                endcase
            end

            always_ff @(posedge pipe_stage_reg_clk_i) begin
                if (!pipe_stage_reg_clrn_i) begin
                    r_state    <= ST_EMPTY;
                    r_main_pc  <= PC_RST;
                    r_main_dat <= '0;
                    r_skid_pc  <= '0;
                    r_skid_dat <= '0;
                end else if (pipe_stage_reg_flush_i) begin
                    r_state    <= ST_EMPTY;
                    r_main_pc  <= '0;
                    r_main_dat <= '0;
                    r_skid_pc  <= '0;
                    r_skid_dat <= '0;
                end else begin
                    r_state <= w_state_next;
                    if (w_load_main) begin
                        r_main_pc  <= pipe_stage_reg_pc_i;
                        r_main_dat <= pipe_stage_reg_dat_i;
                    end else if (w_main_from_skid) begin
                        r_main_pc  <= r_skid_pc;
                        r_main_dat <= r_skid_dat;
                    end
                    if (w_load_skid) begin
                        r_skid_pc  <= pipe_stage_reg_pc_i;
                        r_skid_dat <= pipe_stage_reg_dat_i;
                    end
                end
            end

            // Ready comes straight from state, so it has no path from rdy_i.
            assign w_vld = (r_state != ST_EMPTY);
            assign w_rdy = (r_state != ST_SKID);
            assign w_pc  = r_main_pc;
            assign w_dat = r_main_dat;
        end else begin : g_single
            logic             r_vld;
            logic [PC_W-1:0]  r_pc;
            logic [PAY_W-1:0] r_dat;

            always_ff @(posedge pipe_stage_reg_clk_i) begin
                if (!pipe_stage_reg_clrn_i) begin
                    r_vld <= 1'b0;
                    r_pc  <= PC_RST;
                    r_dat <= '0;
                end else if (pipe_stage_reg_flush_i) begin
                    r_vld <= 1'b0;
                    r_pc  <= '0;
                    r_dat <= '0;
                end else if (w_accept) begin
                    r_vld <= 1'b1;
                    r_pc  <= pipe_stage_reg_pc_i;
                    r_dat <= pipe_stage_reg_dat_i;
                end else if (w_drain) begin
                    // The payload keeps its value. Only the valid flag drops.
                    r_vld <= 1'b0;
                end
            end

            assign w_vld = r_vld;
            assign w_rdy = pipe_stage_reg_rdy_i | ~r_vld;
            assign w_pc  = r_pc;
            assign w_dat = r_dat;
        end
    endgenerate

    // Bubble counter. It counts edges where the output was not valid before
    // the edge, and it stops at all-ones. Flush does not clear it.
    logic [CNT_W-1:0] r_bub;

    always_ff @(posedge pipe_stage_reg_clk_i) begin
        if (!pipe_stage_reg_clrn_i) begin
            r_bub <= '0;
        end else if (!w_vld && (r_bub != {CNT_W{1'b1}})) begin
            r_bub <= r_bub + 1'b1;
        end
    end

    assign pipe_stage_reg_rdy_o = w_rdy;
    assign pipe_stage_reg_vld_o = w_vld;
    assign pipe_stage_reg_pc_o  = w_pc;
    assign pipe_stage_reg_dat_o = w_dat;
    assign pipe_stage_reg_bub_o = r_bub;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Two instances run side by side:
//     - instance 0: SKID=1, CNT_W=4
//     - instance 1: SKID=0, CNT_W=16
//   Each stimulus process drives inputs on the falling edge. At +2 it records
//   accepted beats in a FIFO model. Flush or reset empties that model.
//   Each monitor process samples outputs at +1 after the falling edge. It
//   compares them against the model and pops the model when a beat drains.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int NFIELD = 4;
    localparam int PC_W   = 32;
    localparam int PW     = NFIELD * DATA_W;
    localparam int CYC    = 400;
    localparam logic [PC_W-1:0] PC_RST = 32'h3000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PW-1:0]   dat;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int SKID  = (gi == 0) ? 1 : 0;
            localparam int CNT_W = (gi == 0) ? 4 : 16;
            localparam int BMAX  = (1 << CNT_W) - 1;

            logic              clrn, vld_i, rdy_o, flush, vld_o, rdy_i;
            logic [PC_W-1:0]   pc_i, pc_o;
            logic [PW-1:0]     dat_i, dat_o;
            logic [CNT_W-1:0]  bub_o;

            beat_t q[$];
            beat_t last;
            int    bub_m = 0;
            bit    live  = 1'b0;

            pipe_stage_reg #(
                .DATA_W(DATA_W), .NFIELD(NFIELD), .PC_W(PC_W),
                .PC_RST(PC_RST), .SKID(SKID), .CNT_W(CNT_W)
            ) u_dut (
                .pipe_stage_reg_clk_i  (clk),
                .pipe_stage_reg_clrn_i (clrn),
                .pipe_stage_reg_vld_i  (vld_i),
                .pipe_stage_reg_rdy_o  (rdy_o),
                .pipe_stage_reg_pc_i   (pc_i),
                .pipe_stage_reg_dat_i  (dat_i),
                .pipe_stage_reg_flush_i(flush),
                .pipe_stage_reg_vld_o  (vld_o),
                .pipe_stage_reg_rdy_i  (rdy_i),
                .pipe_stage_reg_pc_o   (pc_o),
                .pipe_stage_reg_dat_o  (dat_o),
                .pipe_stage_reg_bub_o  (bub_o)
            );

            // Stimulus and expected-beat producer.
            initial begin
                int    acc;
                beat_t b;
                acc   = 0;
                clrn  = 1'b0;
                vld_i = 1'b0;
                flush = 1'b0;
                rdy_i = 1'b0;
                pc_i  = '0;
                dat_i = '0;
                for (int cyc = 0; cyc < CYC; cyc++) begin
                    @(negedge clk);
                    dat_i = {$urandom, $urandom, $urandom, $urandom};
                    flush = 1'b0;
                    clrn  = 1'b1;
                    if (cyc == 0) begin
                        // Reset edge.
                        clrn  = 1'b0;
                        vld_i = 1'b0;
                    end else if (cyc <= 20) begin
                        // Idle window that drives the bubble counter to saturation.
                        vld_i = 1'b0;
                        rdy_i = 1'b1;
                    end else if (cyc <= 44) begin
                        // Ordered stream of 12 PCs, with downstream stalled for 4 cycles.
                        vld_i = (acc < 12);
                        pc_i  = PC_RST + 32'(4 * acc);
                        rdy_i = !(cyc >= 26 && cyc <= 29);
                    end else if (cyc <= 48) begin
                        // Fill both entries, then flush while a new beat is offered.
                        vld_i = (cyc != 48);
                        pc_i  = 32'h4000 + 32'(cyc);
                        rdy_i = (cyc == 48);
                        flush = (cyc == 47);
                    end else begin
                        clrn  = ($urandom_range(99) != 0);
                        flush = ($urandom_range(19) == 0);
                        vld_i = ($urandom_range(3) != 0);
                        rdy_i = ($urandom_range(3) != 0);
                        pc_i  = $urandom;
                    end
                    #2;
                    if (!clrn || flush) begin
                        q.delete();
                    end else if (vld_i && rdy_o) begin
                        b.pc  = pc_i;
                        b.dat = dat_i;
                        q.push_back(b);
                        acc++;
                    end
                end
                n_done++;
            end

            // Monitor: compares outputs against the FIFO model.
            initial begin
                bit exp_vld;
                bit exp_rdy;
                last.pc  = PC_RST;
                last.dat = '0;
                for (int cyc = 0; cyc < CYC; cyc++) begin
                    @(negedge clk);
                    #1;
                    exp_vld = (q.size() != 0);
                    if (live) begin
                        if (SKID != 0) exp_rdy = (q.size() < 2);
                        else           exp_rdy = rdy_i || (q.size() == 0);
                        check($sformatf("vld_o dut%0d cyc%0d", gi, cyc), PW'(vld_o), PW'(exp_vld));
                        check($sformatf("rdy_o dut%0d cyc%0d", gi, cyc), PW'(rdy_o), PW'(exp_rdy));
                        check($sformatf("bub_o dut%0d cyc%0d", gi, cyc), PW'(bub_o), PW'(bub_m));
                        if (exp_vld) last = q[0];
                        check($sformatf("pc_o dut%0d cyc%0d", gi, cyc), PW'(pc_o), PW'(last.pc));
                        check($sformatf("dat_o dut%0d cyc%0d", gi, cyc), dat_o, last.dat);
                        if (exp_vld && rdy_i) begin
                            $display("dut%0d cyc%0d beat pc=%h", gi, cyc, q[0].pc);
                            void'(q.pop_front());
                        end
                    end
                    // Model state after the coming edge.
                    if (!clrn) begin
                        last.pc  = PC_RST;
                        last.dat = '0;
                        bub_m    = 0;
                        live     = 1'b1;
                    end else if (live) begin
                        if (!exp_vld && bub_m < BMAX) bub_m++;
                        if (flush) begin
                            last.pc  = '0;
                            last.dat = '0;
                        end
                    end
                end
                n_done++;
            end
        end
    endgenerate

    initial begin
        wait (n_done == 4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
